apb_timer_slave: RTL and testbench

APB peripheral that sits directly downstream of the AHB-to-APB bridge on one of its three select lines. It consumes the bridge's Pselx/Penable/Pwrite/Paddr/Pwdata and returns Prdata. Internally it is a 32-bit down-counting timer with reload, a sticky expiry flag and an interrupt output, so bridge reads and writes have visible sequential effects.

---
 rtl/apb_timer_slave.sv | 170 +++++++++++++++++
 tb/tb_apb_timer_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// apb_timer_slave
// APB slave holding a 32-bit down-counting timer with reload, a sticky expiry flag and a
// level interrupt. Optional build macro: APB_TIMER_PRESCALER_EN adds the PRESC register at
// offset 0x10 and an 8-bit prescaler so the timer ticks once every PRESC+1 clocks.
module apb_timer_slave #(
    parameter int unsigned PSEL_BIT  = 0,
    parameter logic [7:0]  PRESC_RST = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        irq
);
    // Word offsets, Paddr[4:2]
    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrLoad   = 3'd1;
    localparam logic [2:0] AddrCount  = 3'd2;
    localparam logic [2:0] AddrStatus = 3'd3;
`ifdef APB_TIMER_PRESCALER_EN
    localparam logic [2:0] AddrPresc  = 3'd4;
`endif

    logic        r_en;
    logic        r_auto_reload;
    logic        r_irq_en;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_expired;
    logic [31:0] r_prdata;

    logic        w_sel;
    logic        w_rd_setup;
    logic        w_wr;
    logic [2:0]  w_addr;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_zero;
    logic        w_expire;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel       = Pselx[PSEL_BIT];
    assign w_rd_setup  = w_sel & ~Penable & ~Pwrite;
    assign w_wr        = w_sel & Penable & Pwrite;
    assign w_addr      = Paddr[4:2];
    assign w_wr_ctrl   = w_wr & (w_addr == AddrCtrl);
    assign w_wr_load   = w_wr & (w_addr == AddrLoad);
    assign w_wr_count  = w_wr & (w_addr == AddrCount);
    assign w_wr_status = w_wr & (w_addr == AddrStatus);

    // Zero is detected before any decrement, so the counter never wraps below 0.
    assign w_zero   = (r_count == 32'd0);
    assign w_expire = w_tick & w_zero;

`ifdef APB_TIMER_PRESCALER_EN
    logic [7:0] r_presc;
    logic [7:0] r_pcnt;
    logic       w_wr_presc;

    assign w_wr_presc = w_wr & (w_addr == AddrPresc);
    assign w_tick     = r_en & (r_pcnt == r_presc);
    assign w_unused   = ^{Pselx, Paddr[31:5], Paddr[1:0]};

    // PRESC divisor register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= PRESC_RST;
        end else if (w_wr_presc) begin
            r_presc <= Pwdata[7:0];
        end
    end

    // Prescaler counter: parked at 0 while disabled so an EN 0->1 restarts it at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= 8'd0;
        end else if (!r_en || w_tick) begin
            r_pcnt <= 8'd0;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end
`else
    assign w_tick   = r_en;
    assign w_unused = ^{Pselx, Paddr[31:5], Paddr[1:0], PRESC_RST};
`endif

    // Read mux; unmapped offsets return 0.
    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            AddrCtrl:   w_rdata = {29'd0, r_irq_en, r_auto_reload, r_en};
            AddrLoad:   w_rdata = r_load;
            AddrCount:  w_rdata = r_count;
            AddrStatus: w_rdata = {31'd0, r_expired};
`ifdef APB_TIMER_PRESCALER_EN
            AddrPresc:  w_rdata = {24'd0, r_presc};
`endif
            default:    w_rdata = 32'd0;
        endcase
    end

    // Timer core: tick effects first, then bus writes so CTRL/COUNT writes win collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en          <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
            r_load        <= 32'd0;
            r_count       <= 32'd0;
        end else begin
            if (w_tick) begin
                if (w_zero) begin
                    if (r_auto_reload) begin
                        r_count <= r_load;
                    end else begin
                        r_en <= 1'b0;
                    end
                end else begin
                    r_count <= r_count - 32'd1;
                end
            end
            if (w_wr_ctrl) begin
                r_en          <= Pwdata[0];
                r_auto_reload <= Pwdata[1];
                r_irq_en      <= Pwdata[2];
            end
            if (w_wr_load) begin
                r_load <= Pwdata;
            end
            if (w_wr_count) begin
                r_count <= Pwdata;
            end
        end
    end

    // Sticky expiry flag: a same-cycle expiry beats a write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_wr_status && Pwdata[0]) begin
            r_expired <= 1'b0;
        end
    end

    // Read data captured at the end of a read setup phase, zero at every other edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prdata <= 32'd0;
        end else if (w_rd_setup) begin
            r_prdata <= w_rdata;
        end else begin
            r_prdata <= 32'd0;
        end
    end

    assign Prdata = r_prdata;
    assign irq    = r_expired & r_irq_en;

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave
// Directed scenarios plus randomized APB traffic, every cycle compared against a
// behavioural model of the timer register set. Honours APB_TIMER_PRESCALER_EN.
module tb_apb_timer_slave;
    localparam int unsigned PSEL_BIT  = 0;
    localparam logic [7:0]  PRESC_RST = 8'd0;
    localparam logic [2:0]  SelMask   = 3'(1 << PSEL_BIT);

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic        m_en, m_ar, m_ie, m_exp;
    logic [31:0] m_load, m_count, m_prdata;
`ifdef APB_TIMER_PRESCALER_EN
    logic [7:0]  m_presc;
    int          m_since_tick;  // clocks elapsed in the current prescale period
`endif

    always #5 clk = ~clk;

    apb_timer_slave #(
        .PSEL_BIT  (PSEL_BIT),
        .PRESC_RST (PRESC_RST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Pselx   (Pselx),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Paddr   (Paddr),
        .Pwdata  (Pwdata),
        .Prdata  (Prdata),
        .irq     (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {29'd0, m_ie, m_ar, m_en};
            3'd1: return m_load;
            3'd2: return m_count;
            3'd3: return {31'd0, m_exp};
`ifdef APB_TIMER_PRESCALER_EN
            3'd4: return {24'd0, m_presc};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_prdata = 0;
`ifdef APB_TIMER_PRESCALER_EN
        m_presc = PRESC_RST;
        m_since_tick = 0;
`endif
    endtask

    // Apply one clock edge of the timer rules to the model, using the bus inputs of the cycle.
    task automatic model_step();
        logic        sel, wr, tick;
        logic [2:0]  a;
        logic [31:0] rd;
        if (rst) begin
            model_reset();
            return;
        end
        sel = Pselx[PSEL_BIT];
        wr  = sel && Penable && Pwrite;
        a   = Paddr[4:2];
        rd  = model_read(a);
`ifdef APB_TIMER_PRESCALER_EN
        tick = m_en && (m_since_tick % (int'(m_presc) + 1) == int'(m_presc));
        if (!m_en || tick) m_since_tick = 0;
        else m_since_tick = m_since_tick + 1;
`else
        tick = m_en;
`endif
        m_prdata = (sel && !Penable && !Pwrite) ? rd : 32'd0;
        if (wr && a == 3'd3 && Pwdata[0]) m_exp = 0;
        if (tick && m_count == 0) begin
            m_exp = 1;
            if (m_ar) m_count = m_load;
            else m_en = 0;
        end else if (tick) begin
            m_count = m_count - 1;
        end
        if (wr) begin
            case (a)
                3'd0: {m_ie, m_ar, m_en} = Pwdata[2:0];
                3'd1: m_load = Pwdata;
                3'd2: m_count = Pwdata;
`ifdef APB_TIMER_PRESCALER_EN
                3'd4: m_presc = Pwdata[7:0];
`endif
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("prdata", Prdata, m_prdata);
        check_eq("irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
    endtask

    task automatic bus_idle();
        Pselx = 3'd0; Penable = 0; Pwrite = 0;
    endtask

    task automatic idle(input int n);
        bus_idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        Pselx = SelMask; Penable = 0; Pwrite = 1; Paddr = addr; Pwdata = data;
        cycle();
        Penable = 1;
        cycle();
        bus_idle();
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        Pselx = SelMask; Penable = 0; Pwrite = 0; Paddr = addr; Pwdata = $urandom;
        cycle();
        data = Prdata;
        Penable = 1;
        cycle();
        bus_idle();
    endtask

    // Idle until the model count reaches v while running; an expired bound is a failure.
    task automatic wait_count(input logic [31:0] v);
        int k = 0;
        bus_idle();
        while (m_count != v && k < 100) begin
            cycle();
            k++;
        end
        if (k == 100) check_eq("wait_count_timeout", 32'(k), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [2:0]  a;
        int          k;
        int          kind;
        rst = 1; Paddr = 0; Pwdata = 0;
        bus_idle();
        cycle();
        cycle();
        rst = 0;

        // Reset values
        apb_read(32'h00, d); check_eq("rst_ctrl", d, 32'd0);
        apb_read(32'h04, d); check_eq("rst_load", d, 32'd0);
        apb_read(32'h08, d); check_eq("rst_count", d, 32'd0);
        apb_read(32'h0C, d); check_eq("rst_status", d, 32'd0);

        // Write / readback and unmapped offsets
        apb_write(32'h04, 32'h1111_2222);
        apb_read(32'h04, d); check_eq("load_readback", d, 32'h1111_2222);
        apb_write(32'h14, 32'hDEAD_BEEF);
        apb_read(32'h14, d); check_eq("unmapped_14", d, 32'd0);

        // One-shot: COUNT=3, CTRL=EN|IRQ_EN
        apb_write(32'h08, 32'd3);
        apb_write(32'h00, 32'h5);
        apb_read(32'h08, d); check_eq("oneshot_cnt3", d, 32'd3);
        apb_read(32'h08, d); check_eq("oneshot_cnt1", d, 32'd1);
        apb_read(32'h08, d); check_eq("oneshot_cnt0", d, 32'd0);
        check_eq("oneshot_irq", {31'd0, irq}, 32'd1);
        apb_read(32'h0C, d); check_eq("oneshot_expired", d, 32'd1);
        apb_read(32'h00, d); check_eq("oneshot_en_cleared", d, 32'd4);
        apb_read(32'h08, d); check_eq("oneshot_stays0", d, 32'd0);
        apb_write(32'h0C, 32'h0);
        check_eq("status_w0_keeps_irq", {31'd0, irq}, 32'd1);
        apb_write(32'h0C, 32'h1);
        check_eq("status_clear_irq", {31'd0, irq}, 32'd0);

        // Auto-reload: LOAD=2, COUNT=0, CTRL=0x7
        apb_write(32'h04, 32'd2);
        apb_write(32'h08, 32'd0);
        apb_write(32'h00, 32'h7);
        idle(1);
        check_eq("reload_irq", {31'd0, irq}, 32'd1);
        apb_read(32'h08, d); check_eq("reload_cnt2", d, 32'd2);
        wait_count(32'd2);
        apb_write(32'h0C, 32'h1);
        check_eq("reload_irq_drop", {31'd0, irq}, 32'd0);
        idle(1);
        check_eq("reload_irq_again", {31'd0, irq}, 32'd1);

        // Collisions with a longer period: LOAD=5
        apb_write(32'h04, 32'd5);
        wait_count(32'd5);
        apb_write(32'h0C, 32'h1);
        apb_read(32'h0C, d); check_eq("coll_status_cleared", d, 32'd0);
        wait_count(32'd1);
        apb_write(32'h08, 32'h10);  // access edge is the expiry edge
        apb_read(32'h08, d); check_eq("coll_count_write_wins", d, 32'h10);
        apb_read(32'h0C, d); check_eq("coll_expiry_flag", d, 32'd1);
        apb_write(32'h0C, 32'h1);
        wait_count(32'd1);
        apb_write(32'h0C, 32'h1);   // clear lands on the expiry edge
        apb_read(32'h0C, d); check_eq("coll_set_beats_clear", d, 32'd1);
        apb_write(32'h00, 32'h0);
        apb_write(32'h0C, 32'h1);

`ifdef APB_TIMER_PRESCALER_EN
        apb_write(32'h10, 32'd3);
        apb_write(32'h08, 32'd2);
        apb_write(32'h00, 32'h5);
        k = 0;
        bus_idle();
        while (!irq && k < 40) begin
            cycle();
            k++;
        end
        check_eq("presc_expiry_clocks", 32'(k), 32'd12);
        apb_write(32'h00, 32'h0);
        apb_write(32'h0C, 32'h1);
`else
        apb_write(32'h10, 32'd3);
        apb_read(32'h10, d); check_eq("presc_absent", d, 32'd0);
`endif

        // Randomized traffic
        for (int it = 0; it < 500; it++) begin
            kind = $urandom_range(0, 9);
            a = 3'($urandom_range(0, 7));
            case (kind)
                0, 1, 2, 3: begin
                    case (a)
                        3'd0: d = $urandom_range(0, 7) | ($urandom & 32'hFFFF_FFF8);
                        3'd1, 3'd2: d = $urandom_range(0, 12);
                        3'd4: d = $urandom_range(0, 3);
                        default: d = $urandom;
                    endcase
                    apb_write(($urandom & 32'hFFFF_FFE3) | {27'd0, a, 2'd0}, d);
                end
                4, 5, 6: apb_read(($urandom & 32'hFFFF_FFE3) | {27'd0, a, 2'd0}, d);
                7: idle($urandom_range(1, 4));
                8: begin
                    Pselx = 3'($urandom_range(0, 7)) & ~SelMask;
                    Penable = 1'($urandom); Pwrite = 1'($urandom);
                    Paddr = $urandom; Pwdata = $urandom;
                    cycle();
                    bus_idle();
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        Pselx = SelMask; Penable = 0; Pwrite = 1'($urandom);
                        Paddr = 32'h08; Pwdata = $urandom;
                        cycle();
                        rst = 1; Penable = 1;
                        cycle();
                        rst = 0;
                        bus_idle();
                    end else begin
                        idle(1);
                    end
                end
            endcase
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
